// File: rtl/execute_store_data_buffer.sv
// execute_store_data_buffer
//   Turns execute-stage stores (byte address, right-justified register data,
//   size) into word-aligned memory writes with a big-endian byte mask, and
//   queues them in a small FIFO. The FIFO drains to the data-memory port
//   through a req/busy handshake, so execute is not stalled by a busy port.
//
//   Optional feature: define EXECUTE_STORE_MISALIGN_FAULT_EN to reject
//   misaligned half/word stores and pulse oFAULT_MISALIGN. When the macro is
//   undefined, misaligned stores are truncated to their natural alignment.
//
// Ports
//   iCLOCK, inRESET (async, active low), iRESET_SYNC (sync clear)
//   iEXE_VALID/oEXE_BUSY         : store request / FIFO full
//   iEXE_ADDR/DATA/SIZE          : store address, data, size (0=B 1=H 2,3=W)
//   oMEM_REQ/iMEM_BUSY           : head valid / memory stall
//   oMEM_ADDR/MASK/DATA          : head entry, zero when oMEM_REQ=0
//   oEMPTY                       : FIFO empty
//   oFAULT_MISALIGN              : one-cycle misalign pulse (feature only)
module execute_store_data_buffer #(
    parameter int P_DEPTH = 2
) (
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iEXE_VALID,
    output logic        oEXE_BUSY,
    input  logic [31:0] iEXE_ADDR,
    input  logic [31:0] iEXE_DATA,
    input  logic [1:0]  iEXE_SIZE,
    output logic        oMEM_REQ,
    input  logic        iMEM_BUSY,
    output logic [31:0] oMEM_ADDR,
    output logic [3:0]  oMEM_MASK,
    output logic [31:0] oMEM_DATA,
    output logic        oEMPTY,
    output logic        oFAULT_MISALIGN
);
    localparam int PW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [P_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    entry_t          enc;
    logic            enq;
    logic            deq;

    assign oEXE_BUSY = (count == CW'(P_DEPTH));
    assign oMEM_REQ  = (count != '0);
    assign oEMPTY    = (count == '0);

    // Lane encode: offset 0 is the most significant byte of the word.
    always_comb begin
        enc      = '0;
        enc.addr = iEXE_ADDR[31:2];
        case (iEXE_SIZE)
            2'd0: begin
                enc.mask = 4'b0001 << iEXE_ADDR[1:0];
                enc.data = {iEXE_DATA[7:0], 24'h0} >> {iEXE_ADDR[1:0], 3'b000};
            end
            2'd1: begin
                if (iEXE_ADDR[1]) begin
                    enc.mask = 4'b1100;
                    enc.data = {16'h0, iEXE_DATA[15:0]};
                end else begin
                    enc.mask = 4'b0011;
                    enc.data = {iEXE_DATA[15:0], 16'h0};
                end
            end
            default: begin
                enc.mask = 4'b1111;
                enc.data = iEXE_DATA;
            end
        endcase
    end

`ifdef EXECUTE_STORE_MISALIGN_FAULT_EN
    logic misalign;
    logic fault_q;

    assign misalign = ((iEXE_SIZE == 2'd1) && iEXE_ADDR[0]) ||
                      (iEXE_SIZE[1] && (iEXE_ADDR[1:0] != 2'b00));
    assign enq      = iEXE_VALID && !oEXE_BUSY && !misalign;
    assign oFAULT_MISALIGN = fault_q;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET)         fault_q <= 1'b0;
        else if (iRESET_SYNC) fault_q <= 1'b0;
        else                  fault_q <= iEXE_VALID && !oEXE_BUSY && misalign;
    end
`else
    assign enq             = iEXE_VALID && !oEXE_BUSY;
    assign oFAULT_MISALIGN = 1'b0;
`endif

    assign deq = oMEM_REQ && !iMEM_BUSY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= enc;
                wr_ptr      <= (wr_ptr == PW'(P_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (deq)
                rd_ptr <= (rd_ptr == PW'(P_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({enq, deq})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head fields are forced to zero whenever nothing is requested.
    always_comb begin
        oMEM_ADDR = '0;
        oMEM_MASK = '0;
        oMEM_DATA = '0;
        if (oMEM_REQ) begin
            oMEM_ADDR = {mem[rd_ptr].addr, 2'b00};
            oMEM_MASK = mem[rd_ptr].mask;
            oMEM_DATA = mem[rd_ptr].data;
        end
    end
endmodule

// File: tb/tb_execute_store_data_buffer.sv
module tb_execute_store_data_buffer;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sync_rst = 1'b0;
    logic        exe_valid = 1'b0;
    logic        exe_busy;
    logic [31:0] exe_addr = '0;
    logic [31:0] exe_data = '0;
    logic [1:0]  exe_size = '0;
    logic        mem_req;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data;
    logic        empty;
    logic        fault;

    execute_store_data_buffer #(.P_DEPTH(DEPTH)) dut (
        .iCLOCK(clk), .inRESET(rst_n), .iRESET_SYNC(sync_rst),
        .iEXE_VALID(exe_valid), .oEXE_BUSY(exe_busy),
        .iEXE_ADDR(exe_addr), .iEXE_DATA(exe_data), .iEXE_SIZE(exe_size),
        .oMEM_REQ(mem_req), .iMEM_BUSY(mem_busy),
        .oMEM_ADDR(mem_addr), .oMEM_MASK(mem_mask), .oMEM_DATA(mem_data),
        .oEMPTY(empty), .oFAULT_MISALIGN(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } st_t;

`ifdef EXECUTE_STORE_MISALIGN_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif

    st_t  q[$];
    logic fault_m = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Store of n bytes sits at lanes base..base+n-1, base = offset rounded
    // down to n; the most significant source byte goes to the lowest lane.
    function automatic st_t encode(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        st_t e;
        int  n, base, lane;
        n      = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        base   = (int'(a[1:0]) / n) * n;
        e.addr = a;
        e.mask = '0;
        e.data = '0;
        for (int i = 0; i < n; i++) begin
            lane = base + i;
            e.mask[lane] = 1'b1;
            e.data[31 - 8*lane -: 8] = 8'((d >> (8 * (n - 1 - i))) & 32'hff);
        end
        return e;
    endfunction

    function automatic bit misaligned(input logic [31:0] a, input logic [1:0] s);
        int n;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        return (int'(a[1:0]) % n) != 0;
    endfunction

    // Advance the model with the inputs the DUT sampled at this edge.
    task automatic model_update();
        bit acc, mis, deq;
        if (!rst_n || sync_rst) begin
            q.delete();
            fault_m = 1'b0;
            return;
        end
        mis = FAULT_EN && misaligned(exe_addr, exe_size);
        acc = exe_valid && (q.size() < DEPTH);
        deq = (q.size() != 0) && !mem_busy;
        if (deq) void'(q.pop_front());
        if (acc && !mis) q.push_back(encode(exe_addr, exe_data, exe_size));
        fault_m = acc && mis;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] s, input logic mb, input logic sr);
        exe_valid = v; exe_addr = a; exe_data = d; exe_size = s;
        mem_busy = mb; sync_rst = sr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        chk("req",   {31'h0, mem_req},  {31'h0, q.size() != 0});
        chk("busy",  {31'h0, exe_busy}, {31'h0, q.size() == DEPTH});
        chk("empty", {31'h0, empty},    {31'h0, q.size() == 0});
        chk("fault", {31'h0, fault},    {31'h0, fault_m});
        if (q.size() != 0) begin
            chk("addr", mem_addr, {q[0].addr[31:2], 2'b00});
            chk("mask", {28'h0, mem_mask}, {28'h0, q[0].mask});
            chk("data", mem_data, q[0].data);
        end else begin
            chk("addr_idle", mem_addr, 32'h0);
            chk("mask_idle", {28'h0, mem_mask}, 32'h0);
            chk("data_idle", mem_data, 32'h0);
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_req", {31'h0, mem_req}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_busy", {31'h0, exe_busy}, 32'h0);

        // Lane encode literals
        drive(1, 32'h1003, 32'h000000AB, 2'd0, 0, 0);
        chk("b3_req", {31'h0, mem_req}, 32'h1);
        chk("b3_addr", mem_addr, 32'h1000);
        chk("b3_mask", {28'h0, mem_mask}, 32'h8);
        chk("b3_data", mem_data, 32'h000000AB);
        drive(1, 32'h2002, 32'h1234CAFE, 2'd1, 0, 0);
        chk("h2_mask", {28'h0, mem_mask}, 32'hC);
        chk("h2_data", mem_data, 32'h0000CAFE);
        drive(1, 32'h2000, 32'h1234CAFE, 2'd1, 0, 0);
        chk("h0_mask", {28'h0, mem_mask}, 32'h3);
        chk("h0_data", mem_data, 32'hCAFE0000);
        drive(1, 32'h3000, 32'hDEADBEEF, 2'd2, 0, 0);
        chk("w_mask", {28'h0, mem_mask}, 32'hF);
        chk("w_data", mem_data, 32'hDEADBEEF);
        drive(0, 0, 0, 0, 0, 0);
        chk("drain_empty", {31'h0, empty}, 32'h1);

        // Back-pressure: three stores while memory busy
        drive(1, 32'h4000, 32'h11111111, 2'd2, 1, 0);
        drive(1, 32'h5000, 32'h22222222, 2'd2, 1, 0);
        chk("full_busy", {31'h0, exe_busy}, 32'h1);
        chk("full_head", mem_addr, 32'h4000);
        drive(1, 32'h6000, 32'h33333333, 2'd2, 1, 0);
        chk("held_head", mem_data, 32'h11111111);
        chk("held_busy", {31'h0, exe_busy}, 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        chk("second_head", mem_addr, 32'h5000);
        chk("second_busy", {31'h0, exe_busy}, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        chk("bp_empty", {31'h0, empty}, 32'h1);

        // Async reset with a held full FIFO
        drive(1, 32'h7000, 32'h44444444, 2'd2, 1, 0);
        drive(1, 32'h7004, 32'h55555555, 2'd2, 1, 0);
        rst_n = 1'b0;
        q.delete();
        fault_m = 1'b0;
        #1;
        chk("ar_req", {31'h0, mem_req}, 32'h0);
        chk("ar_empty", {31'h0, empty}, 32'h1);
        chk("ar_addr", mem_addr, 32'h0);
        drive(0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        chk("ar_noreq", {31'h0, mem_req}, 32'h0);

        // Misaligned word
        drive(1, 32'h3001, 32'h11223344, 2'd2, 1, 0);
`ifdef EXECUTE_STORE_MISALIGN_FAULT_EN
        chk("mis_fault", {31'h0, fault}, 32'h1);
        chk("mis_empty", {31'h0, empty}, 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        chk("mis_fault_end", {31'h0, fault}, 32'h0);
`else
        chk("mis_mask", {28'h0, mem_mask}, 32'hF);
        chk("mis_addr", mem_addr, 32'h3000);
        drive(0, 0, 0, 0, 0, 0);
`endif
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic, including occasional sync clears
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom(), $urandom(),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 31) == 0));
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
